// File: rtl/vram_ctrl_pkg.sv
// Shared types and constants for the text-mode VRAM port-A sequencer.
// The ops, FSM states and address-space markers live here so that the RTL and any tooling agree on them.
package vram_ctrl_pkg;

  typedef enum logic {
    OP_CLEAR     = 1'b0,
    OP_SCROLL_UP = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_FILL,
    ST_DONE
  } state_e;

  localparam int VRAM_WORDS    = 600;
  localparam int CTRL_ADDR_BIT = 11;

endpackage

// File: rtl/vram_scroll_ctrl.sv
// Port-A arbiter for the 80x30 text VRAM: passes CPU Avalon accesses through when idle,
// otherwise runs the CLEAR / SCROLL_UP bulk engine and stalls the CPU.
module vram_scroll_ctrl
  import vram_ctrl_pkg::*;
#(
  parameter int WORDS_PER_ROW = 20,
  parameter int NUM_ROWS      = 30,
  parameter int ADDR_W        = 11
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_op,
  input  logic [31:0]       i_cmd_fill,
  output logic              o_busy,
  output logic              o_done,
  input  logic              i_cpu_read,
  input  logic              i_cpu_write,
  input  logic [11:0]       i_cpu_addr,
  input  logic [3:0]        i_cpu_byte_en,
  input  logic [31:0]       i_cpu_wdata,
  output logic [31:0]       o_cpu_rdata,
  output logic              o_cpu_waitrequest,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [3:0]        o_ram_byteena,
  output logic [31:0]       o_ram_data,
  output logic              o_ram_wren,
  output logic              o_ram_rden,
  input  logic [31:0]       i_ram_q
);

  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(WORDS_PER_ROW);
  localparam logic [ADDR_W-1:0] LAST_COPY  = ADDR_W'((NUM_ROWS - 1) * WORDS_PER_ROW - 1);
  localparam logic [ADDR_W-1:0] LAST_FILL  = ADDR_W'(NUM_ROWS * WORDS_PER_ROW - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [31:0]       r_fill;

  logic w_idle;
  logic w_cpu_ctrl;
  logic w_accept;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_cpu_ctrl = i_cpu_addr[CTRL_ADDR_BIT];
  // The CPU wins a same-cycle conflict; the command simply waits a cycle.
  assign w_accept   = i_cmd_valid && o_cmd_ready;

  assign o_cmd_ready       = w_idle && !(i_cpu_read || i_cpu_write);
  assign o_busy            = !w_idle;
  assign o_done            = (r_state == ST_DONE);
  assign o_cpu_waitrequest = !w_idle;
  assign o_cpu_rdata       = i_ram_q;

  always_comb begin
    o_ram_addr    = i_cpu_addr[ADDR_W-1:0];
    o_ram_byteena = i_cpu_byte_en;
    o_ram_data    = i_cpu_wdata;
    o_ram_rden    = 1'b0;
    o_ram_wren    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_ram_rden = i_cpu_read && !w_cpu_ctrl;
        o_ram_wren = i_cpu_write && !w_cpu_ctrl;
      end
      ST_RD: begin
        o_ram_rden = 1'b1;
        o_ram_addr = r_cnt + ROW_STRIDE;
      end
      ST_WR: begin
        // Data read from the row below in the previous cycle is written straight back.
        o_ram_wren    = 1'b1;
        o_ram_addr    = r_cnt;
        o_ram_data    = i_ram_q;
        o_ram_byteena = 4'hF;
      end
      ST_FILL: begin
        o_ram_wren    = 1'b1;
        o_ram_addr    = r_cnt;
        o_ram_data    = r_fill;
        o_ram_byteena = 4'hF;
      end
      default: begin
        o_ram_rden = 1'b0;
        o_ram_wren = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_fill  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_fill  <= i_cmd_fill;
            r_cnt   <= '0;
            r_state <= (op_e'(i_cmd_op) == OP_SCROLL_UP) ? ST_RD : ST_FILL;
          end
        end
        ST_RD: r_state <= ST_WR;
        ST_WR: begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == LAST_COPY) ? ST_FILL : ST_RD;
        end
        ST_FILL: begin
          if (r_cnt == LAST_FILL) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_scroll_ctrl.sv
// Directed bench for vram_scroll_ctrl with a byte-enabled VRAM port-A model.
module tb_vram_scroll_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_fill;
  logic        busy, done;
  logic        cpu_read, cpu_write;
  logic [11:0] cpu_addr;
  logic [3:0]  cpu_byte_en;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_waitrequest;
  logic [10:0] ram_addr;
  logic [3:0]  ram_byteena;
  logic [31:0] ram_data, ram_q;
  logic        ram_wren, ram_rden;

  logic [31:0] mem [0:2047];

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  vram_scroll_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op), .i_cmd_fill(cmd_fill),
    .o_busy(busy), .o_done(done),
    .i_cpu_read(cpu_read), .i_cpu_write(cpu_write), .i_cpu_addr(cpu_addr),
    .i_cpu_byte_en(cpu_byte_en), .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata),
    .o_cpu_waitrequest(cpu_waitrequest),
    .o_ram_addr(ram_addr), .o_ram_byteena(ram_byteena), .o_ram_data(ram_data),
    .o_ram_wren(ram_wren), .o_ram_rden(ram_rden), .i_ram_q(ram_q)
  );

  // VRAM port A: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (ram_wren) begin
      for (int b = 0; b < 4; b++)
        if (ram_byteena[b]) mem[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
    end
    if (ram_rden) ram_q <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_write = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_byte_en = be;
    cyc();
    cpu_write = 1'b0;
  endtask

  int n, bad, done_cnt, done_at0, done_at1;
  logic done_seen, ready602;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_fill = '0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_byte_en = '0; cpu_wdata = '0;
    repeat (3) cyc();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_waitreq", {31'd0, cpu_waitrequest}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // CPU passthrough
    cpu_write = 1'b1; cpu_addr = 12'd5; cpu_byte_en = 4'hF; cpu_wdata = 32'h41424344;
    #1;
    chk("pt_wren", {31'd0, ram_wren}, 32'd1);
    chk("pt_addr", {21'd0, ram_addr}, 32'd5);
    chk("pt_waitreq_wr", {31'd0, cpu_waitrequest}, 32'd0);
    chk("pt_ready_cpu_busy", {31'd0, cmd_ready}, 32'd0);
    cyc();
    cpu_write = 1'b0; cpu_read = 1'b1;
    #1;
    chk("pt_rden", {31'd0, ram_rden}, 32'd1);
    cyc();
    cpu_read = 1'b0;
    #1;
    chk("pt_rdata", cpu_rdata, 32'h41424344);
    cpu_wr(12'd5, 32'hFFFFFFFF, 4'b0101);
    cpu_read = 1'b1; cpu_addr = 12'd5;
    cyc();
    cpu_read = 1'b0;
    #1;
    chk("pt_byteen_rdata", cpu_rdata, 32'h41FF43FF);
    cpu_write = 1'b1; cpu_addr = 12'h800; cpu_wdata = 32'h12345678; cpu_byte_en = 4'hF;
    #1;
    chk("pt_ctrl_space_wren", {31'd0, ram_wren}, 32'd0);
    cyc();
    cpu_write = 1'b0;

    // CLEAR
    cpu_wr(12'd600, 32'hDEADBEEF, 4'hF);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_fill = 32'h20202020;
    #1;
    chk("clr_ready", {31'd0, cmd_ready}, 32'd1);
    cyc();
    cmd_valid = 1'b0; cmd_fill = 32'h0;
    chk("clr_c1_busy", {31'd0, busy}, 32'd1);
    chk("clr_c1_data", ram_data, 32'h20202020);
    n = 1;
    while (!done && n < 2000) begin cyc(); n++; end
    chk("clr_done_cycle", n, 32'd601);
    chk("clr_done_ready", {31'd0, cmd_ready}, 32'd0);
    cyc();
    chk("clr_after_done", {31'd0, done}, 32'd0);
    chk("clr_ready_again", {31'd0, cmd_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 600; i++) if (mem[i] !== 32'h20202020) bad++;
    chk("clr_words_bad", bad, 32'd0);
    chk("clr_word600_untouched", mem[600], 32'hDEADBEEF);

    // SCROLL_UP
    for (int i = 0; i < 600; i++) cpu_wr(12'(i), 32'(i), 4'hF);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_fill = 32'h0;
    cyc();
    cmd_valid = 1'b0;
    chk("scr_c1_rden", {31'd0, ram_rden}, 32'd1);
    chk("scr_c1_addr", {21'd0, ram_addr}, 32'd20);
    cyc();
    chk("scr_c2_wr_addr", {21'd0, ram_addr}, 32'd0);
    chk("scr_c2_wr_data", ram_data, 32'd20);
    n = 2;
    while (!done && n < 3000) begin cyc(); n++; end
    chk("scr_done_cycle", n, 32'd1181);
    cyc();
    bad = 0;
    for (int i = 0; i < 580; i++) if (mem[i] !== 32'(i + 20)) bad++;
    for (int i = 580; i < 600; i++) if (mem[i] !== 32'd0) bad++;
    chk("scr_words_bad", bad, 32'd0);

    // Arbitration
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_fill = 32'h11111111;
    cpu_write = 1'b1; cpu_addr = 12'd10; cpu_wdata = 32'hCAFEF00D; cpu_byte_en = 4'hF;
    #1;
    chk("arb_ready_conflict", {31'd0, cmd_ready}, 32'd0);
    cyc();
    cpu_write = 1'b0;
    #1;
    chk("arb_cpu_write_landed", mem[10], 32'hCAFEF00D);
    chk("arb_not_busy", {31'd0, busy}, 32'd0);
    chk("arb_ready_next", {31'd0, cmd_ready}, 32'd1);
    cyc();
    cmd_valid = 1'b0;
    cpu_read = 1'b1; cpu_addr = 12'd10;
    #1;
    chk("arb_waitreq", {31'd0, cpu_waitrequest}, 32'd1);
    chk("arb_no_cpu_rden", {31'd0, ram_rden}, 32'd0);
    n = 1; done_seen = 1'b0;
    while (cpu_waitrequest && n < 2000) begin
      if (done) done_seen = 1'b1;
      cyc(); n++;
    end
    chk("arb_release_cycle", n, 32'd602);
    chk("arb_done_seen", {31'd0, done_seen}, 32'd1);
    cyc();
    cpu_read = 1'b0;
    #1;
    chk("arb_post_rdata", cpu_rdata, 32'h11111111);

    // Reset mid-scroll
    for (int i = 0; i < 600; i++) cpu_wr(12'(i), 32'(i + 1000), 4'hF);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_fill = 32'h0;
    cyc();
    cmd_valid = 1'b0;
    n = 1;
    while (n < 300) begin cyc(); n++; end
    rst_n = 1'b0;
    cyc();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    done_seen = 1'b0;
    repeat (10) begin cyc(); if (done || busy) done_seen = 1'b1; end
    chk("rst_no_done_no_busy", {31'd0, done_seen}, 32'd0);
    chk("rst_mem149", mem[149], 32'd1169);
    chk("rst_mem150", mem[150], 32'd1150);

    // Back-to-back with cmd_valid held
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_fill = 32'h33333333;
    cyc();
    cmd_fill = 32'h44444444;
    n = 1; done_cnt = 0; done_at0 = 0; done_at1 = 0; ready602 = 1'b0;
    while (n < 1215) begin
      if (n == 603) cmd_valid = 1'b0;
      #1;
      if (done) begin
        if (done_cnt == 0) done_at0 = n; else done_at1 = n;
        done_cnt++;
      end
      if (n == 602) ready602 = cmd_ready;
      cyc(); n++;
    end
    chk("b2b_done_count", done_cnt, 32'd2);
    chk("b2b_done0_cycle", done_at0, 32'd601);
    chk("b2b_done1_cycle", done_at1, 32'd1203);
    chk("b2b_ready_after_done", {31'd0, ready602}, 32'd1);
    bad = 0;
    for (int i = 0; i < 600; i++) if (mem[i] !== 32'h44444444) bad++;
    chk("b2b_words_bad", bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
